// File: rtl/spi_pkg.sv
// Shared types and constants for the spi_slave_gen2 block.
package spi_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

    localparam int SYNC_STAGES = 3;

    // Leading edge is the transition away from the idle level set by CPOL.
    function automatic logic lead_is_rise(input int cpol);
        return (cpol == 0);
    endfunction

    function automatic logic sample_on_rise(input int cpol, input int cpha);
        return (cpha == 0) ? lead_is_rise(cpol) : !lead_is_rise(cpol);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall strobes.
module spi_sync
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    // Edges compare the second and third flops so both inputs are settled.
    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave_gen2.sv
// SPI slave, all four CPOL/CPHA modes, word-wide RX/TX handshakes.
// Optional sticky error flags are built when SPI_SLAVE_GEN2_ERR_EN is defined.
module spi_slave_gen2
    import spi_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                CPOL      = 0,
    parameter int                CPHA      = 0,
    parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SCK,
    input  logic              MOSI,
    input  logic              ss_n,
    output logic              MISO,
    output logic              miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic              rx_overrun,
    output logic              tx_underrun
);

    localparam int                CNT_W       = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(DATA_W - 1);
    localparam logic              SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
    localparam logic              SCK_IDLE    = (CPOL != 0);

    logic sck_lvl, sck_rise, sck_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic ss_lvl, ss_rise, ss_fall;

    spi_sync #(.RST_VAL(SCK_IDLE)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .d(SCK),
        .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(MOSI),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );
    spi_sync #(.RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .d(ss_n),
        .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sck_lvl, mosi_rise, mosi_fall, ss_lvl};

    logic sample_edge, shift_edge;
    assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
    assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] tx_shadow_q, tx_shadow_d;
    logic              shadow_full_q, shadow_full_d;
    logic              word_done_q, word_done_d;
    logic              miso_q, miso_d;

    logic              enter, load_now, rx_drop, underrun_set;
    logic [DATA_W-1:0] rx_word, load_word, tx_src;

    // Handshakes: a word moves on any clk where valid && ready; valid is held
    // until that happens, and ready never depends combinationally on valid.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        tx_shift_d    = tx_shift_q;
        tx_shadow_d   = tx_shadow_q;
        shadow_full_d = shadow_full_q;
        word_done_d   = word_done_q;
        miso_d        = miso_q;
        enter         = 1'b0;
        load_now      = 1'b0;
        rx_drop       = 1'b0;
        rx_word       = {rx_shift_q, mosi_lvl};
        load_word     = shadow_full_q ? tx_shadow_q : IDLE_WORD;
        tx_src        = word_done_q ? load_word : tx_shift_q;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d     = ST_SHIFT;
                    bit_cnt_d   = '0;
                    rx_shift_d  = '0;
                    word_done_d = 1'b0;
                    enter       = 1'b1;
                    load_now    = 1'b1;
                    tx_shift_d  = load_word;
                end
            end
            ST_SHIFT: begin
                if (ss_rise) begin
                    // Abort: partial RX and TX words are simply forgotten.
                    state_d     = ST_IDLE;
                    bit_cnt_d   = '0;
                    rx_shift_d  = '0;
                    word_done_d = 1'b0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = rx_word[DATA_W-2:0];
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d   = '0;
                            word_done_d = 1'b1;
                            if (!rx_valid_q || rx_ready) begin
                                rx_data_d  = rx_word;
                                rx_valid_d = 1'b1;
                            end else begin
                                rx_drop = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    if (shift_edge) begin
                        load_now    = word_done_q;
                        word_done_d = 1'b0;
                        // CPHA=1 presents each bit on its shift edge, so MISO
                        // comes from a separate output flop.
                        if (CPHA != 0) begin
                            miso_d     = tx_src[DATA_W-1];
                            tx_shift_d = tx_src << 1;
                        end else begin
                            tx_shift_d = word_done_q ? load_word : (tx_shift_q << 1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A word accepted on a load cycle refills the shadow for the next load.
        if (load_now) begin
            shadow_full_d = 1'b0;
        end
        if (tx_valid && !shadow_full_q) begin
            tx_shadow_d   = tx_data;
            shadow_full_d = 1'b1;
        end
    end

    assign underrun_set = load_now && !shadow_full_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_shift_q    <= '0;
            tx_shadow_q   <= '0;
            shadow_full_q <= 1'b0;
            word_done_q   <= 1'b0;
            miso_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_shift_q    <= tx_shift_d;
            tx_shadow_q   <= tx_shadow_d;
            shadow_full_q <= shadow_full_d;
            word_done_q   <= word_done_d;
            miso_q        <= miso_d;
        end
    end

    assign busy     = (state_q == ST_SHIFT);
    assign miso_oe  = (state_q == ST_SHIFT);
    assign MISO     = miso_oe && ((CPHA != 0) ? miso_q : tx_shift_q[DATA_W-1]);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_ready = !shadow_full_q;

`ifdef SPI_SLAVE_GEN2_ERR_EN
    logic ovr_q, ovr_d;
    logic udr_q, udr_d;

    // Flags restart at each new frame; a set in the same cycle wins.
    always_comb begin
        ovr_d = ovr_q;
        udr_d = udr_q;
        if (enter) begin
            ovr_d = 1'b0;
            udr_d = 1'b0;
        end
        if (rx_drop) begin
            ovr_d = 1'b1;
        end
        if (underrun_set) begin
            udr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
            udr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
            udr_q <= udr_d;
        end
    end

    assign rx_overrun  = ovr_q;
    assign tx_underrun = udr_q;
`else
    logic unused_flags;
    assign unused_flags = ^{enter, rx_drop, underrun_set};
    assign rx_overrun   = 1'b0;
    assign tx_underrun  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_gen2.sv
// Bench for spi_slave_gen2: one 16-bit mode-0 instance and four 8-bit instances (one per mode).
`timescale 1ns/1ps
module tb_spi_slave_gen2;

    localparam int H = 8;  // SCK half period in clk cycles

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  sel;
    logic        sck_bus, mosi_bus, ss_bus, rx_ready_bus, tx_valid_bus;
    logic [15:0] tx_data_bus;
    int          cur_w, cur_cpol, cur_cpha;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = -1;
    logic prev_v = 1'b0;
    bit model_full = 1'b0;
    logic [15:0] exp_q[$];

    // 16-bit instance, mode 0, IDLE_WORD all ones
    logic        d16_miso, d16_oe, d16_rxv, d16_txr, d16_busy, d16_ovr, d16_udr;
    logic [15:0] d16_rxd;

    spi_slave_gen2 #(.DATA_W(16), .CPOL(0), .CPHA(0), .IDLE_WORD(16'hFFFF)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .SCK((sel == 3'd4) ? sck_bus : 1'b0),
        .MOSI(mosi_bus),
        .ss_n((sel == 3'd4) ? ss_bus : 1'b1),
        .MISO(d16_miso), .miso_oe(d16_oe),
        .rx_data(d16_rxd), .rx_valid(d16_rxv),
        .rx_ready((sel == 3'd4) ? rx_ready_bus : 1'b1),
        .tx_data(tx_data_bus),
        .tx_valid((sel == 3'd4) && tx_valid_bus),
        .tx_ready(d16_txr), .busy(d16_busy),
        .rx_overrun(d16_ovr), .tx_underrun(d16_udr)
    );

    // 8-bit instances, index = {CPOL, CPHA}
    logic [3:0] m8_miso, m8_oe, m8_rxv, m8_txr, m8_busy, m8_ovr, m8_udr;
    logic [7:0] m8_rxd [4];

    for (genvar g = 0; g < 4; g++) begin : g_m8
        localparam int GCPOL = g / 2;
        localparam int GCPHA = g % 2;
        spi_slave_gen2 #(.DATA_W(8), .CPOL(GCPOL), .CPHA(GCPHA)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .SCK((sel == 3'(g)) ? sck_bus : (GCPOL != 0)),
            .MOSI(mosi_bus),
            .ss_n((sel == 3'(g)) ? ss_bus : 1'b1),
            .MISO(m8_miso[g]), .miso_oe(m8_oe[g]),
            .rx_data(m8_rxd[g]), .rx_valid(m8_rxv[g]),
            .rx_ready((sel == 3'(g)) ? rx_ready_bus : 1'b1),
            .tx_data(tx_data_bus[7:0]),
            .tx_valid((sel == 3'(g)) && tx_valid_bus),
            .tx_ready(m8_txr[g]), .busy(m8_busy[g]),
            .rx_overrun(m8_ovr[g]), .tx_underrun(m8_udr[g])
        );
    end

    logic        s_miso, s_oe, s_rxv, s_txr, s_busy, s_ovr, s_udr;
    logic [15:0] s_rxd;

    always_comb begin
        if (sel == 3'd4) begin
            s_miso = d16_miso; s_oe = d16_oe; s_rxv = d16_rxv; s_txr = d16_txr;
            s_busy = d16_busy; s_ovr = d16_ovr; s_udr = d16_udr; s_rxd = d16_rxd;
        end else begin
            s_miso = m8_miso[sel[1:0]]; s_oe = m8_oe[sel[1:0]];
            s_rxv = m8_rxv[sel[1:0]]; s_txr = m8_txr[sel[1:0]];
            s_busy = m8_busy[sel[1:0]]; s_ovr = m8_ovr[sel[1:0]];
            s_udr = m8_udr[sel[1:0]]; s_rxd = {8'h00, m8_rxd[sel[1:0]]};
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every accepted RX word is popped and compared.
    always @(negedge clk) begin
        if (rst_n && s_rxv && !prev_v) rise_cyc = cyc;
        prev_v = s_rxv;
        if (rst_n && s_rxv && rx_ready_bus) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %h with no word expected", s_rxd);
            end else begin
                check("rx_data", 32'(s_rxd), 32'(exp_q.pop_front()));
            end
            model_full = 1'b0;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic select_dut(input logic [2:0] k);
        @(negedge clk);
        sel = k;
        if (k == 3'd4) begin
            cur_w = 16; cur_cpol = 0; cur_cpha = 0;
        end else begin
            cur_w = 8; cur_cpol = int'(k[1]); cur_cpha = int'(k[0]);
        end
        sck_bus = (cur_cpol != 0);
        wait_clk(H);
    endtask

    task automatic check_reset_outputs();
        check("rst_rx_valid", 32'(s_rxv), 32'd0);
        check("rst_rx_data", 32'(s_rxd), 32'd0);
        check("rst_tx_ready", 32'(s_txr), 32'd1);
        check("rst_miso", 32'(s_miso), 32'd0);
        check("rst_miso_oe", 32'(s_oe), 32'd0);
        check("rst_busy", 32'(s_busy), 32'd0);
        check("rst_rx_overrun", 32'(s_ovr), 32'd0);
        check("rst_tx_underrun", 32'(s_udr), 32'd0);
    endtask

    task automatic tx_push(input logic [15:0] w);
        int n;
        @(negedge clk);
        tx_valid_bus = 1'b1;
        tx_data_bus = w;
        n = 0;
        while (!s_txr && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_txr) begin
            checks++;
            errors++;
            $display("FAIL tx_ready_timeout: got 0 required 1");
        end
        @(negedge clk);
        tx_valid_bus = 1'b0;
    endtask

    // Master: drives n bits MSB first and collects MISO at the master's sample edge.
    task automatic spi_bits(input logic [15:0] w, input int n, output logic [15:0] got,
                            output int last_cyc);
        logic b;
        got = '0;
        last_cyc = 0;
        ss_bus = 1'b0;
        wait_clk(H);
        for (int i = 0; i < n; i++) begin
            b = w[cur_w-1-i];
            if (cur_cpha == 0) begin
                mosi_bus = b;
                wait_clk(H);
                sck_bus = (cur_cpol == 0);
                got = {got[14:0], s_miso};
                last_cyc = cyc;
                wait_clk(H);
                sck_bus = (cur_cpol != 0);
            end else begin
                wait_clk(H);
                sck_bus = (cur_cpol == 0);
                mosi_bus = b;
                wait_clk(H);
                sck_bus = (cur_cpol != 0);
                got = {got[14:0], s_miso};
                last_cyc = cyc;
            end
        end
        wait_clk(H);
        ss_bus = 1'b1;
        wait_clk(H);
    endtask

    // One full-word frame; the expected responses come from the transfer rules.
    task automatic run_word(input logic [15:0] mosi_w, input bit has_tx, input logic [15:0] tx_w);
        logic [15:0] mask, got, exp_miso;
        int last_cyc, lat;
        bit pushed, exp_ovr, exp_udr;
        mask = (cur_w == 16) ? 16'hFFFF : 16'h00FF;
        if (has_tx) tx_push(tx_w & mask);
        exp_miso = has_tx ? (tx_w & mask) : ((cur_w == 16) ? 16'hFFFF : 16'h0000);
        exp_ovr = model_full;
        pushed = !model_full;
        if (pushed) begin
            exp_q.push_back(mosi_w & mask);
            model_full = 1'b1;
        end
        // Mode 0 style reloads after the last bit, which finds the shadow empty.
        exp_udr = !has_tx || (cur_cpha == 0);
        rise_cyc = -1;
        spi_bits(mosi_w, cur_w, got, last_cyc);
        check("miso_word", 32'(got & mask), 32'(exp_miso));
        if (pushed) begin
            lat = rise_cyc - last_cyc;
            checks++;
            if (rise_cyc < 0 || lat < 1 || lat > 5) begin
                errors++;
                $display("FAIL rx_latency: got %0d clk (rise at %0d) required 1..5", lat, rise_cyc);
            end
        end
`ifdef SPI_SLAVE_GEN2_ERR_EN
        check("rx_overrun", 32'(s_ovr), 32'(exp_ovr));
        check("tx_underrun", 32'(s_udr), 32'(exp_udr));
`else
        check("rx_overrun", 32'(s_ovr), 32'(1'b0 & exp_ovr));
        check("tx_underrun", 32'(s_udr), 32'(1'b0 & exp_udr));
`endif
    endtask

    // Aborted frame of n bits; optionally pulses reset before ss_n rises.
    task automatic spi_partial(input logic [15:0] w, input int n, input bit do_rst);
        logic [15:0] got;
        int last_cyc;
        ss_bus = 1'b0;
        wait_clk(H);
        for (int i = 0; i < n; i++) begin
            mosi_bus = w[cur_w-1-i];
            wait_clk(H);
            sck_bus = (cur_cpol == 0);
            wait_clk(H);
            sck_bus = (cur_cpol != 0);
        end
        if (do_rst) begin
            rst_n = 1'b0;
            @(negedge clk);
            check_reset_outputs();
            rst_n = 1'b1;
            model_full = 1'b0;
        end
        wait_clk(H);
        ss_bus = 1'b1;
        wait_clk(2 * H);
        got = '0;
        last_cyc = 0;
        if (got != 16'h0 || last_cyc != 0) $display("partial frame bookkeeping reset");
    endtask

    initial begin
        sel = 3'd4; cur_w = 16; cur_cpol = 0; cur_cpha = 0;
        sck_bus = 1'b0; mosi_bus = 1'b0; ss_bus = 1'b1;
        rx_ready_bus = 1'b1; tx_valid_bus = 1'b0; tx_data_bus = '0;
        rst_n = 1'b0;
        wait_clk(3);
        check_reset_outputs();
        rst_n = 1'b1;
        wait_clk(4);

        // Directed mode-0 exchange, then an underrun frame
        run_word(16'hA55A, 1'b1, 16'h09BB);
        run_word(16'h5AC3, 1'b0, 16'h0000);

        for (int i = 0; i < 4; i++) begin
            run_word(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
                     16'($urandom_range(0, 65535)));
        end

        // Back-to-back words with the consumer stalled
        @(posedge clk);
        #1 rx_ready_bus = 1'b0;
        run_word(16'hBEEF, 1'b1, 16'h1111);
        run_word(16'hCAFE, 1'b1, 16'h2222);
        check("ovr_kept_data", 32'(s_rxd), 32'h0000BEEF);
        check("ovr_valid_held", 32'(s_rxv), 32'd1);
        @(posedge clk);
        #1 rx_ready_bus = 1'b1;
        wait_clk(4);
        run_word(16'($urandom_range(0, 65535)), 1'b1, 16'($urandom_range(0, 65535)));

        // Aborted 7-bit frame, then a full word
        spi_partial(16'hFFFF, 7, 1'b0);
        run_word(16'h1234, 1'b1, 16'h4321);

        // Reset pulse mid-word, then a full word
        spi_partial(16'h8001, 9, 1'b1);
        run_word(16'($urandom_range(0, 65535)), 1'b1, 16'($urandom_range(0, 65535)));

        // All four SPI modes at 8 bits
        for (int m = 0; m < 4; m++) begin
            select_dut(3'(m));
            run_word(16'h003C, 1'b1, 16'h00C3);
            run_word(16'($urandom_range(0, 255)), 1'b1, 16'($urandom_range(0, 255)));
        end

        wait_clk(10);
        check("rx_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
